// File: rtl/conv_if.sv
// Host handshake, image ROM port and scratch-memory port of the conv accelerator.
// master = accelerator side, slave = host / memory side.
interface conv_if;
    logic        ready;
    logic        busy;
    logic [11:0] iaddr;
    logic [19:0] idata;
    logic        cwr;
    logic [11:0] caddr_wr;
    logic [19:0] cdata_wr;
    logic        crd;
    logic [11:0] caddr_rd;
    logic [19:0] cdata_rd;
    logic [2:0]  csel;

    modport master (
        input  ready, idata, cdata_rd,
        output busy, iaddr, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel
    );

    modport slave (
        output ready, idata, cdata_rd,
        input  busy, iaddr, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel
    );
endinterface

// File: rtl/conv.sv
// 3x3 conv + bias + ReLU over a 64x64 Q4.16 image, then optional 2x2/2 max-pool.
// Macro LAYER1_EN enables the pooling layer; without it the FSM goes CONV -> DONE.
//   state | meaning
//   IDLE  | waiting for ready
//   CONV  | 9 pipelined pixel reads per output, one write per 9 cycles
//   POOL  | 4 layer-0 reads + 1 layer-1 write per output
//   DONE  | drop busy, return to IDLE
module conv (
    input  logic   clk,
    input  logic   reset,
    conv_if.master bus
);
    typedef enum logic [1:0] {IDLE, CONV, POOL, DONE} state_t;

    localparam logic signed [43:0] ACC_INIT = (44'sd4880 <<< 16) + 44'sd32768;

    state_t             state_q;
    logic               busy_q, cwr_q, fin_q;
    logic [2:0]         csel_q;
    logic [11:0]        iaddr_q, caddr_wr_q;
    logic [19:0]        cdata_wr_q;
    logic [5:0]         y_q, x_q;
    logic [3:0]         tap_q, a_tap_q;
    logic               iss_end_q, a_vld_q, a_last_q, a_final_q;
    logic [11:0]        a_addr_q;
    logic signed [43:0] acc_q;

    logic [3:0]         rc_d;
    logic [7:0]         ry_d, rx_d;
    logic               tap_in_d;
    logic signed [39:0] prod_d;
    logic signed [43:0] sum_d;
    logic [19:0]        relu_d;

    function automatic logic signed [19:0] kern(input logic [3:0] t);
        case (t)
            4'd0:    return 20'sh0A89E;
            4'd1:    return 20'sh092D5;
            4'd2:    return 20'sh06D43;
            4'd3:    return 20'sh01004;
            4'd4:    return 20'shF8F71;
            4'd5:    return 20'shF6E54;
            4'd6:    return 20'shFA6D7;
            4'd7:    return 20'shFC834;
            default: return 20'shFAC19;
        endcase
    endfunction

    // {row, col} offset of a tap inside the 3x3 window
    function automatic logic [3:0] tap_rc(input logic [3:0] t);
        case (t)
            4'd0:    return 4'b00_00;
            4'd1:    return 4'b00_01;
            4'd2:    return 4'b00_10;
            4'd3:    return 4'b01_00;
            4'd4:    return 4'b01_01;
            4'd5:    return 4'b01_10;
            4'd6:    return 4'b10_00;
            4'd7:    return 4'b10_01;
            default: return 4'b10_10;
        endcase
    endfunction

    always_comb begin
        rc_d     = tap_rc(tap_q);
        ry_d     = {2'b00, y_q} + {6'b0, rc_d[3:2]} - 8'd1;
        rx_d     = {2'b00, x_q} + {6'b0, rc_d[1:0]} - 8'd1;
        // -1 wraps to 0xFF and 64 sets bit 6, so both fall outside 0..63
        tap_in_d = (ry_d[7:6] == 2'b00) && (rx_d[7:6] == 2'b00);
        prod_d   = $signed(bus.idata) * kern(a_tap_q);
        sum_d    = acc_q + (a_vld_q ? $signed({{4{prod_d[39]}}, prod_d}) : 44'sd0);
        relu_d   = sum_d[43] ? 20'd0 : sum_d[35:16];
    end

`ifdef LAYER1_EN
    logic        crd_q, pfin_q;
    logic [11:0] caddr_rd_q;
    logic [4:0]  r_q, c_q;
    logic [2:0]  pstep_q;
    logic [19:0] mx_q, mx_d;

    always_comb begin
        mx_d = (crd_q && (bus.cdata_rd > mx_q)) ? bus.cdata_rd : mx_q;
    end

    assign bus.crd      = crd_q;
    assign bus.caddr_rd = caddr_rd_q;
`else
    assign bus.crd      = 1'b0;
    assign bus.caddr_rd = 12'd0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            cwr_q      <= 1'b0;
            csel_q     <= 3'b000;
            iaddr_q    <= 12'd0;
            caddr_wr_q <= 12'd0;
            cdata_wr_q <= 20'd0;
            y_q        <= 6'd0;
            x_q        <= 6'd0;
            tap_q      <= 4'd0;
            a_tap_q    <= 4'd0;
            iss_end_q  <= 1'b0;
            a_vld_q    <= 1'b0;
            a_last_q   <= 1'b0;
            a_final_q  <= 1'b0;
            a_addr_q   <= 12'd0;
            acc_q      <= 44'sd0;
            fin_q      <= 1'b0;
`ifdef LAYER1_EN
            crd_q      <= 1'b0;
            caddr_rd_q <= 12'd0;
            r_q        <= 5'd0;
            c_q        <= 5'd0;
            pstep_q    <= 3'd0;
            mx_q       <= 20'd0;
            pfin_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    cwr_q  <= 1'b0;
                    csel_q <= 3'b000;
                    if (bus.ready) begin
                        busy_q    <= 1'b1;
                        state_q   <= CONV;
                        y_q       <= 6'd0;
                        x_q       <= 6'd0;
                        tap_q     <= 4'd0;
                        iss_end_q <= 1'b0;
                        a_vld_q   <= 1'b0;
                        a_last_q  <= 1'b0;
                        a_final_q <= 1'b0;
                        fin_q     <= 1'b0;
                        acc_q     <= ACC_INIT;
                    end
                end
                CONV: begin
                    if (fin_q) begin
                        cwr_q  <= 1'b0;
                        csel_q <= 3'b000;
`ifdef LAYER1_EN
                        state_q <= POOL;
                        r_q     <= 5'd0;
                        c_q     <= 5'd0;
                        pstep_q <= 3'd0;
                        mx_q    <= 20'd0;
                        pfin_q  <= 1'b0;
`else
                        state_q <= DONE;
`endif
                    end else begin
                        // issue stage: one tap per cycle, next output starts right after tap 8
                        if (!iss_end_q) begin
                            if (tap_in_d) iaddr_q <= {ry_d[5:0], rx_d[5:0]};
                            a_vld_q   <= tap_in_d;
                            a_tap_q   <= tap_q;
                            a_addr_q  <= {y_q, x_q};
                            a_last_q  <= (tap_q == 4'd8);
                            a_final_q <= (tap_q == 4'd8) && (y_q == 6'd63) && (x_q == 6'd63);
                            if (tap_q == 4'd8) begin
                                tap_q <= 4'd0;
                                x_q   <= x_q + 6'd1;
                                if (x_q == 6'd63) y_q <= y_q + 6'd1;
                                if ((y_q == 6'd63) && (x_q == 6'd63)) iss_end_q <= 1'b1;
                            end else begin
                                tap_q <= tap_q + 4'd1;
                            end
                        end else begin
                            a_vld_q  <= 1'b0;
                            a_last_q <= 1'b0;
                        end
                        // accumulate stage, one cycle behind issue
                        if (a_last_q) begin
                            cwr_q      <= 1'b1;
                            csel_q     <= 3'b001;
                            caddr_wr_q <= a_addr_q;
                            cdata_wr_q <= relu_d;
                            acc_q      <= ACC_INIT;
                            fin_q      <= a_final_q;
                        end else begin
                            cwr_q  <= 1'b0;
                            csel_q <= 3'b000;
                            acc_q  <= sum_d;
                        end
                    end
                end
`ifdef LAYER1_EN
                POOL: begin
                    if (pfin_q) begin
                        cwr_q   <= 1'b0;
                        crd_q   <= 1'b0;
                        csel_q  <= 3'b000;
                        state_q <= DONE;
                    end else if (pstep_q == 3'd4) begin
                        crd_q      <= 1'b0;
                        cwr_q      <= 1'b1;
                        csel_q     <= 3'b011;
                        caddr_wr_q <= {2'b00, r_q, c_q};
                        cdata_wr_q <= mx_d;
                        mx_q       <= 20'd0;
                        pstep_q    <= 3'd0;
                        c_q        <= c_q + 5'd1;
                        if (c_q == 5'd31) r_q <= r_q + 5'd1;
                        if ((r_q == 5'd31) && (c_q == 5'd31)) pfin_q <= 1'b1;
                    end else begin
                        cwr_q      <= 1'b0;
                        crd_q      <= 1'b1;
                        csel_q     <= 3'b001;
                        caddr_rd_q <= {r_q, pstep_q[1], c_q, pstep_q[0]};
                        mx_q       <= mx_d;
                        pstep_q    <= pstep_q + 3'd1;
                    end
                end
`endif
                DONE: begin
                    busy_q  <= 1'b0;
                    cwr_q   <= 1'b0;
                    csel_q  <= 3'b000;
                    state_q <= IDLE;
`ifdef LAYER1_EN
                    crd_q   <= 1'b0;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.iaddr    = iaddr_q;
    assign bus.cwr      = cwr_q;
    assign bus.caddr_wr = caddr_wr_q;
    assign bus.cdata_wr = cdata_wr_q;
    assign bus.csel     = csel_q;
endmodule

// File: tb/tb_conv.sv
// Bench for conv: composite image (point pulses, all-ones corner, random patches),
// mid-run reset, then a full run compared against a loop-level reference model.
module tb_conv;
    logic clk = 1'b0;
    logic reset;
    conv_if bus();

    conv u_dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    logic [19:0] img [4096];
    logic [19:0] l0  [4096];
    logic [19:0] l1  [1024];
    logic [19:0] e0  [4096];
    logic [19:0] e1  [1024];
    logic [19:0] kern [9] = '{20'h0A89E, 20'h092D5, 20'h06D43, 20'h01004, 20'hF8F71,
                              20'hF6E54, 20'hFA6D7, 20'hFC834, 20'hFAC19};

    int ncmp = 0, nbad = 0;
    int nw0, nw1, perr, nsel3, ncyc = 0, last_wr_cyc, fall_cyc;
    logic busy_prev;

    // memories and protocol monitor, sampled mid-cycle
    always @(negedge clk) begin
        ncyc = ncyc + 1;
        bus.idata    = img[bus.iaddr];
        bus.cdata_rd = (bus.crd && bus.csel == 3'b001) ? l0[bus.caddr_rd] : 20'h0;
        if (!reset) begin
            if (bus.cwr && bus.crd) perr = perr + 1;
            if (!bus.cwr && !bus.crd && bus.csel != 3'b000) perr = perr + 1;
            if (bus.csel == 3'b011) nsel3 = nsel3 + 1;
            if (bus.cwr) begin
                last_wr_cyc = ncyc;
                if (bus.csel == 3'b001) begin
                    l0[bus.caddr_wr] = bus.cdata_wr;
                    nw0 = nw0 + 1;
                end else if (bus.csel == 3'b011) begin
                    l1[bus.caddr_wr[9:0]] = bus.cdata_wr;
                    nw1 = nw1 + 1;
                end else begin
                    perr = perr + 1;
                end
            end
            if (busy_prev && !bus.busy) fall_cyc = ncyc;
            busy_prev = bus.busy;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp = ncmp + 1;
        assert (obs === exp) else begin
            nbad = nbad + 1;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic longint sx(input logic [19:0] v);
        return longint'($signed(v));
    endfunction

    // reference: direct arithmetic over the 3x3 window, then 2x2 maxima
    function automatic void build_ref();
        for (int y = 0; y < 64; y++)
            for (int x = 0; x < 64; x++) begin
                longint acc = 64'sd4880 * 65536 + 32768;
                for (int dy = -1; dy <= 1; dy++)
                    for (int dx = -1; dx <= 1; dx++)
                        if (y + dy >= 0 && y + dy < 64 && x + dx >= 0 && x + dx < 64)
                            acc += sx(img[(y + dy) * 64 + x + dx]) * sx(kern[(dy + 1) * 3 + dx + 1]);
                e0[y * 64 + x] = (acc < 0) ? 20'h0 : 20'((acc >>> 16) & 64'hFFFFF);
            end
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++) begin
                logic [19:0] m = 20'h0;
                for (int k = 0; k < 4; k++) begin
                    logic [19:0] v = e0[(2 * r + k / 2) * 64 + 2 * c + k % 2];
                    if (v > m) m = v;
                end
                e1[r * 32 + c] = m;
            end
    endfunction

    task automatic clear_outputs();
        for (int i = 0; i < 4096; i++) l0[i] = 20'h5A5A5;
        for (int i = 0; i < 1024; i++) l1[i] = 20'h5A5A5;
        nw0 = 0; nw1 = 0; perr = 0; nsel3 = 0;
        last_wr_cyc = 0; fall_cyc = 0; busy_prev = 1'b0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"},     bus.busy,     0);
        chk({tag, "_cwr"},      bus.cwr,      0);
        chk({tag, "_crd"},      bus.crd,      0);
        chk({tag, "_csel"},     bus.csel,     0);
        chk({tag, "_iaddr"},    bus.iaddr,    0);
        chk({tag, "_caddr_wr"}, bus.caddr_wr, 0);
        chk({tag, "_caddr_rd"}, bus.caddr_rd, 0);
        chk({tag, "_cdata_wr"}, bus.cdata_wr, 0);
    endtask

    task automatic start_run(input string tag);
        bus.ready = 1'b1;
        for (int i = 0; i < 10 && bus.busy !== 1'b1; i++) @(negedge clk);
        chk({tag, "_busy_rise"}, bus.busy, 1);
        bus.ready = 1'b0;
    endtask

    initial begin
        int bad, first;
        reset = 1'b1;
        bus.ready = 1'b0;
        clear_outputs();
        for (int i = 0; i < 4096; i++) img[i] = 20'h0;
        img[32 * 64 + 32] = 20'h10000;
        img[16 * 64 + 16] = 20'h08000;
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) img[r * 64 + c] = 20'h10000;
        for (int r = 48; r < 64; r++) for (int c = 0; c < 32; c++) img[r * 64 + c] = 20'($urandom_range(0, 20'hFFFFF));
        for (int r = 0; r < 6; r++) for (int c = 58; c < 64; c++) img[r * 64 + c] = 20'($urandom_range(0, 20'hFFFFF));
        build_ref();

        repeat (3) @(negedge clk);
        chk_idle_outputs("rst");
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_no_ready_busy", bus.busy, 0);

        // partial run, then asynchronous reset in the middle of CONV
        start_run("run1");
        for (int i = 0; i < 6000 && nw0 < 500; i++) @(negedge clk);
        chk("run1_reached_500_writes", nw0 >= 500, 1);
        #2 reset = 1'b1;
        #1 chk_idle_outputs("midrst");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        clear_outputs();
        repeat (2) @(negedge clk);

        // full run after the reset
        start_run("run2");
        for (int i = 0; i < 60000 && bus.busy !== 1'b0; i++) @(negedge clk);
        chk("run2_busy_fall", bus.busy, 0);
        repeat (4) @(negedge clk);
        chk("run2_busy_stays_low", bus.busy, 0);
        chk("l0_write_count", nw0, 4096);
        chk("protocol_errors", perr, 0);
        chk("busy_fall_after_last_write", fall_cyc - last_wr_cyc, 2);

        bad = 0; first = 0;
        for (int i = 0; i < 4096; i++) if (l0[i] !== e0[i]) begin if (bad == 0) first = i; bad++; end
        ncmp = ncmp + 1;
        assert (bad == 0) else begin
            nbad = nbad + 1;
            $error("FAIL l0_vs_model: %0d words differ, first at %0d observed 0x%0h expected 0x%0h", bad, first, l0[first], e0[first]);
        end
        chk("l0_2080_relu",      l0[2080],         20'h00000);
        chk("l0_33_33_pulse",    l0[33 * 64 + 33], 20'h0BBAE);
        chk("l0_33_32_pulse",    l0[33 * 64 + 32], 20'h0A5E5);
        chk("l0_32_33_pulse",    l0[32 * 64 + 33], 20'h02314);
        chk("l0_17_16_round_up", l0[17 * 64 + 16], 20'h05C7B);
        chk("l0_17_17_round",    l0[17 * 64 + 17], 20'h0675F);
        chk("l0_corner_0",       l0[0],            20'h00000);
        chk("l0_interior_65",    l0[65],           20'h00000);
        chk("l0_zero_region",    l0[8 * 64 + 30],  20'h01310);

`ifdef LAYER1_EN
        chk("l1_write_count", nw1, 1024);
        bad = 0; first = 0;
        for (int i = 0; i < 1024; i++) if (l1[i] !== e1[i]) begin if (bad == 0) first = i; bad++; end
        ncmp = ncmp + 1;
        assert (bad == 0) else begin
            nbad = nbad + 1;
            $error("FAIL l1_vs_model: %0d words differ, first at %0d observed 0x%0h expected 0x%0h", bad, first, l1[first], e1[first]);
        end
        chk("l1_528_pool", l1[528], 20'h0BBAE);
        chk("l1_zero_region", l1[300], 20'h01310);
`else
        chk("no_l1_writes", nw1, 0);
        chk("no_csel_011", nsel3, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end
endmodule

// File: doc/conv.md
Name: conv

Overview:
- Fixed-function CNN accelerator. Reads a 64x64 image of signed fixed-point pixels (Q4.16, 20 bit) from the host image ROM port.
- Layer 0: 3x3 convolution with kernel 0, zero padding, bias, rounding and ReLU; writes 4096 results to the layer-0 buffer.
- Layer 1: reads layer 0 back, applies 2x2 stride-2 max-pooling, writes 1024 results to the layer-1 buffer.
- Sits between the host handshake (ready/busy) and an external scratch memory selected by csel.

Parameters:
- None. Kernel and bias are hard-coded constants: K0..K8 (row-major, top-left first) = 0x0A89E, 0x092D5, 0x06D43, 0x01004, 0xF8F71, 0xF6E54, 0xFA6D7, 0xFC834, 0xFAC19; BIAS = 0x01310.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- ready  in  1  host has image available; held high until busy seen high
- busy  out  1  high from accept of ready until last layer-1 write done
- iaddr  out  12  image pixel address, row*64+col
- idata  in  20  pixel at iaddr, valid at the rising edge after iaddr is driven
- cwr  out  1  memory write strobe, data committed at the rising edge where cwr=1
- caddr_wr  out  12  write address
- cdata_wr  out  20  write data
- crd  out  1  memory read strobe
- caddr_rd  out  12  read address
- cdata_rd  in  20  read data, valid at the rising edge after crd/caddr_rd/csel are driven
- csel  out  3  memory select: 000 none, 001 layer-0 buffer, 011 layer-1 buffer

Behaviour:
- Reset (any time, including mid-operation): FSM returns to IDLE; busy, cwr, crd, iaddr, caddr_wr, caddr_rd, cdata_wr and csel are all 0.
- FSM: IDLE -> CONV -> POOL -> DONE -> IDLE.
- IDLE: when ready=1 at a rising edge, busy goes 1 on that edge and CONV starts.
- CONV: for each output (y,x), y and x from 0 to 63 in raster order:
  - Issue 9 reads of pixels (y-1..y+1, x-1..x+1); the product for a position with row or col outside 0..63 is forced to 0 (no address issued or data ignored).
  - One-cycle read latency; reads are pipelined.
  - Each product is signed 20x20 -> 40 bit (Q8.32). Accumulate in at least 44 bits signed.
  - acc = sum(products) + (BIAS<<16) + (1<<15); result = acc[35:16].
  - ReLU: if acc < 0 the result is 0x00000.
  - Write with cwr=1, csel=001, caddr_wr = y*64+x, for exactly one cycle per output.
- POOL: for each output (r,c), r and c from 0 to 31:
  - Read layer-0 addresses (2r)*64+2c, +1, +64, +65 with crd=1, csel=001.
  - Take the unsigned max; inputs are non-negative after ReLU.
  - Write with cwr=1, csel=011, caddr_wr = r*32+c.
- cwr and crd are never both high in the same cycle; csel is 000 whenever neither is high.
- DONE: busy goes 0 one edge after the final layer-1 write; go to IDLE. A new ready restarts the full operation.
- iaddr is held, not x, when not reading. idata is ignored outside CONV.
- Throughput is not specified. Target at most 12 cycles per conv output and 6 per pool output.

Optional Feature:
- Macro LAYER1_EN, defined in the default build.
- Defined: POOL stage is executed as above.
- Undefined: POOL logic is omitted; FSM goes CONV -> DONE, busy drops after write of address 4095, and csel never equals 011.

Test Plan:
- All-zero image, ready pulse -> all 4096 layer-0 words = 0x01310; all 1024 layer-1 words = 0x01310; busy returns to 0.
- Image zero except pixel (32,32)=0x10000 ->
  - L0[2080]=0 (ReLU of 0xFA281);
  - L0[33*64+33]=0x0BBAE; L0[33*64+32]=0x0A5E5; L0[32*64+33]=0x02314;
  - L1[528]=0x0BBAE.
- Rounding: pixel (32,32)=0x08000, rest 0 -> L0[33*64+32]=0x05C7B (0x496A.8 rounds up) and L0[33*64+33]=0x0675F.
- Corner padding: image all 0x10000 -> L0[0]=round(K4+K5+K7+K8)+BIAS clipped by ReLU = 0. Interior L0[65] = sum(K0..K8)+BIAS clipped by ReLU.
- Reset asserted mid-CONV (e.g. after 500 writes) -> all outputs 0 immediately. A new ready then produces the full correct result of scenario 2.
- Build without LAYER1_EN -> no write with csel=011; busy falls after layer-0 address 4095 is written.
